// File: rtl/h75_pkg.sv
// Shared types and widths for the HUB75 framebuffer write path.
package h75_pkg;

  localparam int unsigned H75_ADDR_W   = 14;
  localparam int unsigned H75_DATA_W   = 16;
  localparam int unsigned H75_PAGE_BIT = 14;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_CPU,
    GNT_DMA
  } h75_gnt_t;

  typedef enum logic {
    StIdle,
    StPending
  } h75_swap_st_t;

endpackage

// File: rtl/h75_fb_write_scheduler_if.sv
// Requester, swap-control and framebuffer write-port signals of the write scheduler.
interface h75_fb_write_scheduler_if #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 16
);

  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_data;
  logic              cpu_ack;
  logic              dma_valid;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_data;
  logic              dma_ready;
  logic              swap_req;
  logic              frame_sync_in;
  logic              swap_pending;
  logic              front_page;
  logic              fb_wr_en;
  logic [ADDR_W:0]   fb_wr_addr;
  logic [DATA_W-1:0] fb_wr_data;

  modport slave (
    input  cpu_req, cpu_addr, cpu_data, dma_valid, dma_addr, dma_data, swap_req, frame_sync_in,
    output cpu_ack, dma_ready, swap_pending, front_page, fb_wr_en, fb_wr_addr, fb_wr_data
  );

  modport master (
    output cpu_req, cpu_addr, cpu_data, dma_valid, dma_addr, dma_data, swap_req, frame_sync_in,
    input  cpu_ack, dma_ready, swap_pending, front_page, fb_wr_en, fb_wr_addr, fb_wr_data
  );

endinterface

// File: rtl/h75_pulse_sync.sv
// Two-flop synchronizer for a slow-domain level/pulse with a rising-edge strobe in clk.
module h75_pulse_sync (
  input  logic clk,
  input  logic resetn,
  input  logic pulse_i,
  output logic rise_o
);

  // [0],[1] are the synchronizer stages, [2] holds the previous synchronized value.
  logic [2:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], pulse_i};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rise_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/h75_fb_write_scheduler.sv
// Arbitrates CPU and DMA writes onto the framebuffer back page and applies page swaps on frames.
module h75_fb_write_scheduler
  import h75_pkg::*;
#(
  parameter int unsigned ADDR_W    = H75_ADDR_W,
  parameter int unsigned DATA_W    = H75_DATA_W,
  parameter int unsigned BURST_MAX = 16
) (
  input logic                     clk,
  input logic                     resetn,
  h75_fb_write_scheduler_if.slave bus
);

  localparam logic [7:0] BurstMax = 8'(BURST_MAX);

  h75_gnt_t          gnt;
  logic              cpu_elig;
  logic              fs_rise;
  logic [7:0]        run_q, run_d;
  logic              guard_q, guard_d;
  h75_swap_st_t      swap_q, swap_d;
  logic              front_q, front_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  h75_pulse_sync u_fs_sync (
    .clk     (clk),
    .resetn  (resetn),
    .pulse_i (bus.frame_sync_in),
    .rise_o  (fs_rise)
  );

  // The cycle right after a CPU ack is reserved so the requester can drop or replace cpu_req.
  always_comb begin
    gnt      = GNT_NONE;
    cpu_elig = bus.cpu_req & ~guard_q;
    if (resetn) begin
      if (bus.dma_valid && (!cpu_elig || (run_q < BurstMax))) begin
        gnt = GNT_DMA;
      end else if (cpu_elig) begin
        gnt = GNT_CPU;
      end
    end
  end

  assign bus.cpu_ack   = (gnt == GNT_CPU);
  assign bus.dma_ready = (gnt == GNT_DMA);

  always_comb begin
    run_d   = run_q;
    guard_d = (gnt == GNT_CPU);
    if (!bus.cpu_req || (gnt == GNT_CPU)) begin
      run_d = '0;
    end else if ((gnt == GNT_DMA) && (run_q < BurstMax)) begin
      run_d = run_q + 8'd1;
    end
  end

  // Page bit comes from the pre-toggle front page even when a swap lands this cycle.
  always_comb begin
    wr_en_d   = (gnt != GNT_NONE);
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    unique case (gnt)
      GNT_CPU: begin
        wr_addr_d = {~front_q, bus.cpu_addr};
        wr_data_d = bus.cpu_data;
      end
      GNT_DMA: begin
        wr_addr_d = {~front_q, bus.dma_addr};
        wr_data_d = bus.dma_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    swap_d  = swap_q;
    front_d = front_q;
    unique case (swap_q)
      StIdle: begin
        if (bus.swap_req) begin
          swap_d = StPending;
        end
      end
      StPending: begin
        if (fs_rise) begin
          swap_d  = StIdle;
          front_d = ~front_q;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      run_q     <= '0;
      guard_q   <= 1'b0;
      swap_q    <= StIdle;
      front_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      run_q     <= run_d;
      guard_q   <= guard_d;
      swap_q    <= swap_d;
      front_q   <= front_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.swap_pending = (swap_q == StPending);
  assign bus.front_page   = front_q;
  assign bus.fb_wr_en     = wr_en_q;
  assign bus.fb_wr_addr   = wr_addr_q;
  assign bus.fb_wr_data   = wr_data_q;

endmodule

// File: tb/tb_h75_fb_write_scheduler.sv
// Directed and randomized checks of the write scheduler against a behavioural reference model.
module tb_h75_fb_write_scheduler;
  import h75_pkg::*;

  localparam int unsigned AW = 14;
  localparam int unsigned DW = 16;
  localparam int unsigned BM = 16;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #10 clk = ~clk;

  h75_fb_write_scheduler_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  h75_fb_write_scheduler #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .BURST_MAX (BM)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  bit          m_en = 0;
  logic [AW:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  int          m_run = 0;
  bit          m_ack_prev = 0;
  bit          m_pend = 0;
  bit          m_front = 0;
  bit          fs_hist[$] = '{0, 0, 0};  // [0] newest sample

  function automatic h75_gnt_t mdl_grant();
    bit cpu_wants;
    cpu_wants = bus.cpu_req && !m_ack_prev;
    if (!resetn) return GNT_NONE;
    if (cpu_wants && bus.dma_valid) return (m_run < int'(BM)) ? GNT_DMA : GNT_CPU;
    if (cpu_wants) return GNT_CPU;
    if (bus.dma_valid) return GNT_DMA;
    return GNT_NONE;
  endfunction

  initial begin : model_proc
    h75_gnt_t g;
    bit rise;
    forever begin
      @(negedge clk);
      g = mdl_grant();
      chk("cpu_ack", 32'(bus.cpu_ack), 32'(g == GNT_CPU));
      chk("dma_ready", 32'(bus.dma_ready), 32'(g == GNT_DMA));
      chk("fb_wr_en", 32'(bus.fb_wr_en), 32'(m_en));
      chk("fb_wr_addr", 32'(bus.fb_wr_addr), 32'(m_addr));
      chk("fb_wr_data", 32'(bus.fb_wr_data), 32'(m_data));
      chk("swap_pending", 32'(bus.swap_pending), 32'(m_pend));
      chk("front_page", 32'(bus.front_page), 32'(m_front));
      if (!resetn) begin
        m_en = 0; m_addr = '0; m_data = '0; m_run = 0; m_ack_prev = 0;
        m_pend = 0; m_front = 0; fs_hist = '{0, 0, 0};
      end else begin
        m_en = (g != GNT_NONE);
        if (g == GNT_CPU) begin
          m_addr = {~m_front, bus.cpu_addr};
          m_data = bus.cpu_data;
        end else if (g == GNT_DMA) begin
          m_addr = {~m_front, bus.dma_addr};
          m_data = bus.dma_data;
        end
        if (!bus.cpu_req || g == GNT_CPU) m_run = 0;
        else if (g == GNT_DMA) m_run = (m_run + 1 > int'(BM)) ? int'(BM) : m_run + 1;
        m_ack_prev = (g == GNT_CPU);
        rise = fs_hist[1] && !fs_hist[2];
        if (rise && m_pend) begin
          m_front = !m_front;
          m_pend  = 0;
        end else if (bus.swap_req) begin
          m_pend = 1;
        end
        fs_hist.push_front(bus.frame_sync_in);
        void'(fs_hist.pop_back());
      end
    end
  end

  // ---------------- write capture for the burst test ----------------
  int cyc = 0;
  bit cap_on = 0;
  logic [AW+DW:0] cap_q[$];
  int cap_cyc[$];

  initial begin : cyc_proc
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  initial begin : cap_proc
    forever begin
      @(negedge clk);
      if (cap_on && bus.fb_wr_en) begin
        cap_q.push_back({bus.fb_wr_addr, bus.fb_wr_data});
        cap_cyc.push_back(cyc);
      end
    end
  end

  task automatic frame(input int hold);
    bus.frame_sync_in = 1'b1;
    repeat (hold) tick();
    bus.frame_sync_in = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : main_proc
    int beat, dgr, ackdma, cycles, wait_cyc, fs_cnt;
    bit cpu_done, ack_seen;
    logic [5:0] ack_pat;
    logic [AW+DW:0] exp_w;

    bus.cpu_req = 0; bus.cpu_addr = '0; bus.cpu_data = '0;
    bus.dma_valid = 0; bus.dma_addr = '0; bus.dma_data = '0;
    bus.swap_req = 0; bus.frame_sync_in = 0;
    resetn = 0;
    repeat (3) tick();
    chk("rst_fb_wr_en", 32'(bus.fb_wr_en), 0);
    chk("rst_fb_wr_addr", 32'(bus.fb_wr_addr), 0);
    chk("rst_front_page", 32'(bus.front_page), 0);
    chk("rst_swap_pending", 32'(bus.swap_pending), 0);

    // Single CPU write, uncontended.
    resetn = 1;
    bus.cpu_req = 1; bus.cpu_addr = 14'h0123; bus.cpu_data = 16'hBEEF;
    #1;
    chk("cpu1_ack_same_cycle", 32'(bus.cpu_ack), 1);
    chk("release_no_wr_en", 32'(bus.fb_wr_en), 0);
    tick();
    bus.cpu_req = 0;
    chk("cpu1_wr_en", 32'(bus.fb_wr_en), 1);
    chk("cpu1_wr_addr", 32'(bus.fb_wr_addr), 32'h4123);
    chk("cpu1_wr_data", 32'(bus.fb_wr_data), 32'hBEEF);
    tick();
    chk("cpu1_idle_wr_en", 32'(bus.fb_wr_en), 0);
    chk("cpu1_addr_hold", 32'(bus.fb_wr_addr), 32'h4123);

    // 40-beat DMA stream, CPU joins at beat 5.
    cap_on = 1; beat = 0; dgr = 0; ackdma = -1; cpu_done = 0; cycles = 0;
    while ((beat < 40 || !cpu_done) && cycles < 200) begin
      bus.dma_valid = (beat < 40);
      bus.dma_addr  = 14'(beat);
      bus.dma_data  = 16'hD000 + 16'(beat);
      bus.cpu_req   = (beat >= 5) && !cpu_done;
      bus.cpu_addr  = 14'h0AAA;
      bus.cpu_data  = 16'hCAFE;
      #1;
      if (bus.cpu_req && bus.dma_ready) dgr++;
      if (bus.cpu_ack) begin
        cpu_done = 1;
        ackdma = dgr;
      end
      if (bus.dma_ready) beat++;
      tick();
      cycles++;
    end
    bus.dma_valid = 0; bus.cpu_req = 0;
    chk("burst_timeout", 32'(cycles < 200), 1);
    tick();
    tick();
    cap_on = 0;
    chk("burst_dma_before_ack", 32'(ackdma), 16);
    chk("burst_write_count", 32'(cap_q.size()), 41);
    if (cap_q.size() == 41) begin
      for (int k = 0; k < 41; k++) begin
        if (k < 21) exp_w = {1'b1, 14'(k), 16'hD000 + 16'(k)};
        else if (k == 21) exp_w = {1'b1, 14'h0AAA, 16'hCAFE};
        else exp_w = {1'b1, 14'(k - 1), 16'hD000 + 16'(k - 1)};
        chk("burst_order", 32'(cap_q[k]), 32'(exp_w));
      end
      chk("burst_no_gap", 32'(cap_cyc[40] - cap_cyc[0]), 40);
    end

    // Swap on a frame edge.
    bus.swap_req = 1;
    tick();
    bus.swap_req = 0;
    chk("swap_armed", 32'(bus.swap_pending), 1);
    bus.frame_sync_in = 1;
    tick();
    chk("swap_wait1_front", 32'(bus.front_page), 0);
    tick();
    chk("swap_wait2_front", 32'(bus.front_page), 0);
    chk("swap_wait2_pend", 32'(bus.swap_pending), 1);
    tick();
    chk("swap_front_toggled", 32'(bus.front_page), 1);
    chk("swap_pend_cleared", 32'(bus.swap_pending), 0);
    tick();
    bus.frame_sync_in = 0;
    bus.cpu_req = 1; bus.cpu_addr = 14'h0055; bus.cpu_data = 16'h1234;
    #1;
    chk("swap_cpu_ack", 32'(bus.cpu_ack), 1);
    tick();
    bus.cpu_req = 0;
    chk("swap_new_back_page", 32'(bus.fb_wr_addr), 32'h0055);

    // swap_req coincident with the synchronized edge.
    repeat (4) tick();
    bus.frame_sync_in = 1;
    tick();
    tick();
    bus.swap_req = 1;
    tick();
    bus.swap_req = 0;
    chk("coinc_no_toggle", 32'(bus.front_page), 1);
    chk("coinc_pending", 32'(bus.swap_pending), 1);
    tick();
    bus.frame_sync_in = 0;
    repeat (4) tick();
    frame(3);
    chk("coinc_next_frame_toggle", 32'(bus.front_page), 0);
    chk("coinc_pend_cleared", 32'(bus.swap_pending), 0);

    // Double swap_req yields one toggle.
    repeat (4) tick();
    bus.swap_req = 1;
    tick();
    bus.swap_req = 0;
    tick();
    bus.swap_req = 1;
    tick();
    bus.swap_req = 0;
    frame(3);
    chk("dbl_first_toggle", 32'(bus.front_page), 1);
    repeat (4) tick();
    frame(3);
    chk("dbl_no_second_toggle", 32'(bus.front_page), 1);

    // Reset during a DMA burst with a swap armed.
    repeat (4) tick();
    bus.swap_req = 1;
    tick();
    bus.swap_req = 0;
    bus.dma_valid = 1;
    for (int i = 0; i < 5; i++) begin
      bus.dma_addr = 14'($urandom);
      bus.dma_data = 16'($urandom);
      tick();
    end
    chk("rstmid_pending_before", 32'(bus.swap_pending), 1);
    resetn = 0;
    #1;
    chk("rstmid_dma_ready_low", 32'(bus.dma_ready), 0);
    tick();
    chk("rstmid_wr_en", 32'(bus.fb_wr_en), 0);
    chk("rstmid_wr_addr", 32'(bus.fb_wr_addr), 0);
    chk("rstmid_wr_data", 32'(bus.fb_wr_data), 0);
    chk("rstmid_pending", 32'(bus.swap_pending), 0);
    chk("rstmid_front", 32'(bus.front_page), 0);
    tick();
    resetn = 1;
    #1;
    chk("rstmid_release_wr_en", 32'(bus.fb_wr_en), 0);
    tick();
    bus.dma_valid = 0;
    chk("rstmid_post_grant_wr_en", 32'(bus.fb_wr_en), 1);

    // Back-to-back CPU requests, no DMA.
    repeat (2) tick();
    ack_pat = '0;
    for (int i = 0; i < 6; i++) begin
      bus.cpu_req  = 1;
      bus.cpu_addr = 14'(16'h0100 + 16'(i));
      bus.cpu_data = 16'(i);
      #1;
      ack_pat[i] = bus.cpu_ack;
      tick();
    end
    bus.cpu_req = 0;
    chk("b2b_ack_pattern", 32'(ack_pat), 32'b010101);

    // Randomized traffic.
    fs_cnt = 8; wait_cyc = 0; ack_seen = 0;
    for (int c = 0; c < 4000; c++) begin
      resetn = ($urandom_range(0, 699) != 0);
      if (fs_cnt == 0) begin
        bus.frame_sync_in = !bus.frame_sync_in;
        fs_cnt = bus.frame_sync_in ? $urandom_range(2, 5) : $urandom_range(6, 40);
      end
      fs_cnt--;
      bus.swap_req  = ($urandom_range(0, 24) == 0);
      bus.dma_valid = ($urandom_range(0, 3) != 0);
      bus.dma_addr  = 14'($urandom);
      bus.dma_data  = 16'($urandom);
      if (ack_seen) begin
        ack_seen = 0;
        if ($urandom_range(0, 1) == 0) bus.cpu_req = 0;
        bus.cpu_addr = 14'($urandom);
        bus.cpu_data = 16'($urandom);
      end else if (!bus.cpu_req && $urandom_range(0, 5) == 0) begin
        bus.cpu_req  = 1;
        bus.cpu_addr = 14'($urandom);
        bus.cpu_data = 16'($urandom);
      end
      #1;
      if (!resetn) begin
        wait_cyc = 0;
      end else if (bus.cpu_ack) begin
        chk("cpu_latency_bound", 32'(wait_cyc <= int'(BM)), 1);
        wait_cyc = 0;
        ack_seen = 1;
      end else if (bus.cpu_req) begin
        wait_cyc++;
      end
      tick();
    end
    resetn = 1;
    bus.cpu_req = 0; bus.dma_valid = 0; bus.swap_req = 0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
